pipe_hazard_unit: RTL and testbench
===================================

Name: pipe_hazard_unit

Overview:
- Parametrised hazard, forwarding and flush controller for the multi-stage rv32 pipeline. It generalises stage depth, register-address width, load latency and branch-flush length.
- Keeps a scoreboard shift register of in-flight writers, one entry per stage after decode.
- From that scoreboard it drives forwarding selects for the ALU operand muxes, a load-use stall, bubble insertion and a multi-cycle fetch/decode flush after taken branches.
- Sits between decode_ctl/execute_ctl and the PC/operand muxes in the core top.

Parameters:
- REG_ADDR_W, 5, register address width; register 0 is hardwired zero.
- DEPTH, 3, number of tracked stages after decode (entry 0 = EX, 1 = MEM, 2 = WB); legal range 1..7.
- LOAD_LAT, 1, a load's data is forwardable only from entry index >= LOAD_LAT; legal range 0..DEPTH-1.
- FLUSH_CYCLES, 2, number of cycles flush_fd stays high after a taken branch; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- hold  in  1  external freeze request (e.g. dmem wait).
- de_valid  in  1  decode stage holds a real instruction.
- de_rs1  in  REG_ADDR_W  source register A.
- de_rs2  in  REG_ADDR_W  source register B.
- de_rs1_used  in  1  instruction reads rs1.
- de_rs2_used  in  1  instruction reads rs2.
- de_rd  in  REG_ADDR_W  destination register.
- de_reg_we  in  1  instruction writes rd.
- de_is_load  in  1  instruction is a load.
- br_taken  in  1  one-cycle pulse from execute when a branch or jump redirects the PC.
- stall_fd  out  1  hold PC and the decode pipeline register.
- bubble_ex  out  1  insert a NOP into EX this cycle.
- flush_fd  out  1  squash fetch/decode contents.
- fwd_sel_a  out  FW=$clog2(DEPTH+1)  operand A source: 0 = register file, k = entry k-1.
- fwd_sel_b  out  FW  operand B source, same encoding.

Behaviour:
- Scoreboard: DEPTH entries {valid, rd, we, is_load}. All entries are invalid at reset.
- Update rule, on each clock edge:
  - hold=1: no change.
  - Otherwise entries shift toward higher index, and entry DEPTH-1 is dropped.
  - Entry 0 loads the decode instruction when de_valid & !stall_fd & !flush_fd; otherwise entry 0 loads a bubble (valid=0).
- Match rule: entry i matches rsX when valid & we & rd==rsX & rsX!=0 & rsX_used.
- Forwarding (combinational): fwd_sel_X = i+1 for the lowest-index (youngest) match, else 0. rs1 and rs2 are evaluated independently, so both may forward from different entries in the same cycle.
- Load-use (combinational): load_hz = de_valid & (for rs1 or rs2, the youngest match has is_load and index < LOAD_LAT).
- Output equations:
  - stall_fd = hold | (load_hz & !br_taken & !flush_fd).
  - bubble_ex = !hold & (load_hz | flush_fd | br_taken).
  - With LOAD_LAT=0, load_hz is never asserted.
- While stall_fd is high, fwd_sel outputs remain valid for the current decode operands.
- Flush counter: width $clog2(FLUSH_CYCLES+1), reset 0.
  - br_taken loads FLUSH_CYCLES, including while already nonzero (restart).
  - Otherwise, if the counter is nonzero and hold=0, it decrements.
  - hold freezes the counter, except that br_taken still loads it.
  - flush_fd = (counter != 0), a registered output. It rises the cycle after the br_taken pulse and stays high for exactly FLUSH_CYCLES un-held cycles.
- Priority: br_taken / flush beats load-use stall, because the squashed instruction must not stall. hold beats everything for scoreboard and stall_fd.
- Reset: when rst goes low mid-operation, all entries are cleared and the counter is zeroed asynchronously.
- Reset values: stall_fd=0, bubble_ex=0, flush_fd=0, fwd_sel_a=0, fwd_sel_b=0. Note that stall_fd and bubble_ex stay 0 only while hold=0.
- de_rd==0 with de_reg_we=1 is tracked, but it never matches because rs==0 is excluded.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, two extra outputs are added:
  - stall_count (32 bits): counts cycles with load_hz & !hold.
  - flush_count (32 bits): counts br_taken pulses.
- Both counters saturate at 0xFFFFFFFF and reset to 0.
- When undefined, the ports and counters are absent and core behaviour is identical.

Test Plan:
- Back-to-back ALU RAW: issue rd=5 (we), then rs1=5 → fwd_sel_a=1. One cycle later, a second reader of x5 → fwd_sel_a=2. No stall.
- Load-use (LOAD_LAT=1): load rd=7, then next instruction rs2=7.
  - First cycle: stall_fd=1, bubble_ex=1 for exactly 1 cycle.
  - Next cycle: fwd_sel_b=2, stall_fd=0.
- x0 and unused operands: writer rd=0 followed by rs1=0, and writer rd=3 followed by rs2=3 with rs2_used=0 → both fwd_sel=0, no stall.
- Branch flush (FLUSH_CYCLES=2):
  - br_taken pulse at cycle t → flush_fd=1 at t+1 and t+2, 0 at t+3.
  - br_taken in the same cycle as a load hazard → stall_fd=0.
  - Second br_taken at t+1 → flush_fd is held through t+3.
- hold=1 for 3 cycles with entries {rd=4, rd=6}: scoreboard and counter are unchanged, stall_fd=1, bubble_ex=0. On release, the shift resumes.
- Async reset: assert rst=0 mid-flush with a load pending → all outputs are 0 immediately, without a clock edge. After rst=1, the first reader of that rd gets fwd_sel=0.

Source files
------------

// File: rtl/pipe_hazard_unit_if.sv
// pipe_hazard_unit_if: decode/execute side signals of the hazard unit.
// master = pipeline control (decode_ctl/execute_ctl), slave = hazard unit.
interface pipe_hazard_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 3
);
    localparam int FW = $clog2(DEPTH + 1);

    logic                  hold;
    logic                  de_valid;
    logic [REG_ADDR_W-1:0] de_rs1;
    logic [REG_ADDR_W-1:0] de_rs2;
    logic                  de_rs1_used;
    logic                  de_rs2_used;
    logic [REG_ADDR_W-1:0] de_rd;
    logic                  de_reg_we;
    logic                  de_is_load;
    logic                  br_taken;
    logic                  stall_fd;
    logic                  bubble_ex;
    logic                  flush_fd;
    logic [FW-1:0]         fwd_sel_a;
    logic [FW-1:0]         fwd_sel_b;

    modport master (
        output hold, de_valid, de_rs1, de_rs2, de_rs1_used, de_rs2_used,
               de_rd, de_reg_we, de_is_load, br_taken,
        input  stall_fd, bubble_ex, flush_fd, fwd_sel_a, fwd_sel_b
    );

    modport slave (
        input  hold, de_valid, de_rs1, de_rs2, de_rs1_used, de_rs2_used,
               de_rd, de_reg_we, de_is_load, br_taken,
        output stall_fd, bubble_ex, flush_fd, fwd_sel_a, fwd_sel_b
    );
endinterface

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: scoreboard of in-flight writers (entry 0 = EX), driving
// operand forwarding selects, load-use stall, EX bubble and the multi-cycle
// fetch/decode flush after a taken branch.
// Optional macro HAZARD_PERF_EN adds saturating stall/flush event counters.

// One scoreboard entry compared against one decode source operand.
module phu_match #(
    parameter int W = 5
) (
    input  logic         vld,
    input  logic         we,
    input  logic [W-1:0] rd,
    input  logic [W-1:0] rs,
    input  logic         used,
    output logic         hit
);
    // x0 never matches, so writers of rd=0 stay harmless in the scoreboard
    assign hit = vld & we & used & (rd == rs) & (rs != '0);
endmodule

module pipe_hazard_unit #(
    parameter int REG_ADDR_W   = 5,
    parameter int DEPTH        = 3,
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_unit_if.slave  hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]        stall_count,
    output logic [31:0]        flush_count
`endif
);
    localparam int FW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    typedef struct packed {
        logic                  vld;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
        logic                  ld;
    } sb_t;

    sb_t [DEPTH-1:0] sb;
    logic [DEPTH-1:0] hit_a, hit_b;
    logic [FW-1:0]    sel_a, sel_b;
    logic             hz_a, hz_b, load_hz;
    logic [CW-1:0]    fl_cnt;
    logic             flush;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        phu_match #(.W(REG_ADDR_W)) u_ma (
            .vld(sb[i].vld), .we(sb[i].we), .rd(sb[i].rd),
            .rs(hz.de_rs1), .used(hz.de_rs1_used), .hit(hit_a[i])
        );
        phu_match #(.W(REG_ADDR_W)) u_mb (
            .vld(sb[i].vld), .we(sb[i].we), .rd(sb[i].rd),
            .rs(hz.de_rs2), .used(hz.de_rs2_used), .hit(hit_b[i])
        );
    end

    // youngest match wins: scan oldest to youngest so lower index overwrites
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        hz_a  = 1'b0;
        hz_b  = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hit_a[i]) begin
                sel_a = FW'(i + 1);
                hz_a  = sb[i].ld && (i < LOAD_LAT);
            end
            if (hit_b[i]) begin
                sel_b = FW'(i + 1);
                hz_b  = sb[i].ld && (i < LOAD_LAT);
            end
        end
    end

    assign load_hz      = hz.de_valid & (hz_a | hz_b);
    assign flush        = (fl_cnt != '0);
    assign hz.flush_fd  = flush;
    assign hz.fwd_sel_a = sel_a;
    assign hz.fwd_sel_b = sel_b;
    // a squashed instruction must not stall; hold always freezes fetch/decode
    assign hz.stall_fd  = hz.hold | (load_hz & ~hz.br_taken & ~flush);
    assign hz.bubble_ex = ~hz.hold & (load_hz | flush | hz.br_taken);

    // scoreboard shift; entry 0 takes decode only if it actually advances
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb <= '0;
        end else if (!hz.hold) begin
            for (int i = DEPTH - 1; i > 0; i--) sb[i] <= sb[i-1];
            if (hz.de_valid && !hz.stall_fd && !flush)
                sb[0] <= '{vld: 1'b1, rd: hz.de_rd, we: hz.de_reg_we, ld: hz.de_is_load};
            else
                sb[0] <= '0;
        end
    end

    // flush counter: br_taken (re)loads even under hold, hold freezes countdown
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            fl_cnt <= '0;
        else if (hz.br_taken)
            fl_cnt <= CW'(FLUSH_CYCLES);
        else if (flush && !hz.hold)
            fl_cnt <= fl_cnt - 1'b1;
    end

`ifdef HAZARD_PERF_EN
    // saturating event counters for stalled cycles and taken branches
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (load_hz && !hz.hold && stall_count != '1) stall_count <= stall_count + 1'b1;
            if (hz.br_taken && flush_count != '1) flush_count <= flush_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: directed scenarios plus randomized traffic checked
// against a queue-based model of the in-flight instruction window.
module tb_pipe_hazard_unit;
    localparam int RW = 5, DEPTH = 3, LOAD_LAT = 1, FC = 2;
    localparam int FW = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_unit_if #(.REG_ADDR_W(RW), .DEPTH(DEPTH)) hif ();
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_count, flush_count;
`endif

    pipe_hazard_unit #(.REG_ADDR_W(RW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .hz(hif)
`ifdef HAZARD_PERF_EN
        , .stall_count(stall_count), .flush_count(flush_count)
`endif
    );

    int nvec = 0, nerr = 0;

    // model: window of issued instructions, youngest at the front
    typedef struct { bit v; int rd; bit we; bit ld; } ent_t;
    ent_t q[$];
    int   m_flush;

    task automatic model_clear();
        ent_t b = '{v: 0, rd: 0, we: 0, ld: 0};
        q.delete();
        for (int i = 0; i < DEPTH; i++) q.push_back(b);
        m_flush = 0;
    endtask

    task automatic model_eval(output int sa, output int sb, output bit st, output bit bub, output bit fl);
        bit f1 = 0, f2 = 0, h1 = 0, h2 = 0, lh;
        int r1 = int'(hif.de_rs1), r2 = int'(hif.de_rs2);
        sa = 0; sb = 0;
        for (int i = 0; i < q.size(); i++) begin
            if (!f1 && q[i].v && q[i].we && q[i].rd == r1 && r1 != 0 && hif.de_rs1_used) begin
                f1 = 1; sa = i + 1; h1 = q[i].ld && (i < LOAD_LAT);
            end
            if (!f2 && q[i].v && q[i].we && q[i].rd == r2 && r2 != 0 && hif.de_rs2_used) begin
                f2 = 1; sb = i + 1; h2 = q[i].ld && (i < LOAD_LAT);
            end
        end
        lh  = hif.de_valid && (h1 || h2);
        fl  = m_flush > 0;
        st  = hif.hold || (lh && !hif.br_taken && !fl);
        bub = !hif.hold && (lh || fl || hif.br_taken);
    endtask

    task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit we, input bit ld, input bit br, input bit hold);
        hif.de_valid = v;   hif.de_rs1 = RW'(rs1); hif.de_rs1_used = u1;
        hif.de_rs2 = RW'(rs2); hif.de_rs2_used = u2; hif.de_rd = RW'(rd);
        hif.de_reg_we = we; hif.de_is_load = ld; hif.br_taken = br; hif.hold = hold;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // one clock: advance the model with the inputs present at the edge
    task automatic tick();
        int sa, sb; bit st, bub, fl;
        ent_t e;
        model_eval(sa, sb, st, bub, fl);
        @(posedge clk);
        if (!rst) model_clear();
        else begin
            if (!hif.hold) begin
                e = '{v: 0, rd: 0, we: 0, ld: 0};
                if (hif.de_valid && !st && !fl)
                    e = '{v: 1, rd: int'(hif.de_rd), we: hif.de_reg_we, ld: hif.de_is_load};
                q.push_front(e);
                q.delete(q.size() - 1);
            end
            if (hif.br_taken) m_flush = FC;
            else if (m_flush > 0 && !hif.hold) m_flush--;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic reset_dut();
        idle();
        rst = 1'b0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        idle();
        nvec++; if (hif.stall_fd  !== 1'b0) begin nerr++; $display("FAIL reset_stall got %0b exp 0", hif.stall_fd); end
        nvec++; if (hif.bubble_ex !== 1'b0) begin nerr++; $display("FAIL reset_bubble got %0b exp 0", hif.bubble_ex); end
        nvec++; if (hif.flush_fd  !== 1'b0) begin nerr++; $display("FAIL reset_flush got %0b exp 0", hif.flush_fd); end
        nvec++; if (hif.fwd_sel_a !== FW'(0)) begin nerr++; $display("FAIL reset_fwd_a got %0d exp 0", hif.fwd_sel_a); end
        nvec++; if (hif.fwd_sel_b !== FW'(0)) begin nerr++; $display("FAIL reset_fwd_b got %0d exp 0", hif.fwd_sel_b); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        nvec++; if (hif.flush_fd !== 1'b0) begin nerr++; $display("FAIL reset_rel_flush got %0b exp 0", hif.flush_fd); end
    endtask

    task automatic test_back_to_back();
        reset_dut();
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); tick();
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        nvec++; if (hif.fwd_sel_a !== FW'(1)) begin nerr++; $display("FAIL b2b_fwd1 got %0d exp 1", hif.fwd_sel_a); end
        nvec++; if (hif.stall_fd !== 1'b0) begin nerr++; $display("FAIL b2b_stall1 got %0b exp 0", hif.stall_fd); end
        tick();
        nvec++; if (hif.fwd_sel_a !== FW'(2)) begin nerr++; $display("FAIL b2b_fwd2 got %0d exp 2", hif.fwd_sel_a); end
        nvec++; if (hif.stall_fd !== 1'b0) begin nerr++; $display("FAIL b2b_stall2 got %0b exp 0", hif.stall_fd); end
        idle(); tick();
    endtask

    task automatic test_load_use();
        reset_dut();
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0); tick();
        drive(1, 0, 0, 7, 1, 1, 1, 0, 0, 0);
        nvec++; if (hif.stall_fd  !== 1'b1) begin nerr++; $display("FAIL lu_stall got %0b exp 1", hif.stall_fd); end
        nvec++; if (hif.bubble_ex !== 1'b1) begin nerr++; $display("FAIL lu_bubble got %0b exp 1", hif.bubble_ex); end
        tick();
        nvec++; if (hif.stall_fd  !== 1'b0) begin nerr++; $display("FAIL lu_stall2 got %0b exp 0", hif.stall_fd); end
        nvec++; if (hif.bubble_ex !== 1'b0) begin nerr++; $display("FAIL lu_bubble2 got %0b exp 0", hif.bubble_ex); end
        nvec++; if (hif.fwd_sel_b !== FW'(2)) begin nerr++; $display("FAIL lu_fwd_b got %0d exp 2", hif.fwd_sel_b); end
        idle(); tick();
    endtask

    task automatic test_x0_unused();
        reset_dut();
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0); tick();
        drive(1, 0, 1, 0, 0, 3, 1, 0, 0, 0);
        nvec++; if (hif.fwd_sel_a !== FW'(0)) begin nerr++; $display("FAIL x0_fwd_a got %0d exp 0", hif.fwd_sel_a); end
        nvec++; if (hif.stall_fd !== 1'b0) begin nerr++; $display("FAIL x0_stall got %0b exp 0", hif.stall_fd); end
        tick();
        drive(1, 0, 1, 3, 0, 0, 0, 0, 0, 0);
        nvec++; if (hif.fwd_sel_b !== FW'(0)) begin nerr++; $display("FAIL unused_fwd_b got %0d exp 0", hif.fwd_sel_b); end
        nvec++; if (hif.fwd_sel_a !== FW'(0)) begin nerr++; $display("FAIL x0_fwd_a2 got %0d exp 0", hif.fwd_sel_a); end
        idle(); tick();
    endtask

    task automatic test_branch_flush();
        bit exp1 [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        bit exp2 [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        reset_dut();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        nvec++; if (hif.flush_fd !== 1'b0) begin nerr++; $display("FAIL br_flush_t got %0b exp 0", hif.flush_fd); end
        nvec++; if (hif.bubble_ex !== 1'b1) begin nerr++; $display("FAIL br_bubble_t got %0b exp 1", hif.bubble_ex); end
        tick(); idle();
        for (int k = 0; k < 4; k++) begin
            nvec++; if (hif.flush_fd !== exp1[k]) begin nerr++; $display("FAIL br_flush_t%0d got %0b exp %0b", k + 1, hif.flush_fd, exp1[k]); end
            tick();
        end
        // restart: second pulse one cycle after the first
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            nvec++; if (hif.flush_fd !== exp2[k]) begin nerr++; $display("FAIL br_restart_t%0d got %0b exp %0b", k + 1, hif.flush_fd, exp2[k]); end
            tick(); idle();
        end
        // branch coinciding with a load-use hazard: no stall
        drive(1, 0, 0, 0, 0, 8, 1, 1, 0, 0); tick();
        drive(1, 8, 1, 0, 0, 0, 0, 0, 1, 0);
        nvec++; if (hif.stall_fd !== 1'b0) begin nerr++; $display("FAIL br_lu_stall got %0b exp 0", hif.stall_fd); end
        nvec++; if (hif.bubble_ex !== 1'b1) begin nerr++; $display("FAIL br_lu_bubble got %0b exp 1", hif.bubble_ex); end
        tick(); idle(); tick(); tick();
    endtask

    task automatic test_hold();
        reset_dut();
        drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 6, 1, 0, 0, 0); tick();
        for (int k = 0; k < 3; k++) begin
            drive(1, 4, 1, 6, 1, 9, 0, 0, 0, 1);
            nvec++; if (hif.stall_fd  !== 1'b1) begin nerr++; $display("FAIL hold_stall%0d got %0b exp 1", k, hif.stall_fd); end
            nvec++; if (hif.bubble_ex !== 1'b0) begin nerr++; $display("FAIL hold_bubble%0d got %0b exp 0", k, hif.bubble_ex); end
            nvec++; if (hif.fwd_sel_a !== FW'(2)) begin nerr++; $display("FAIL hold_fwd_a%0d got %0d exp 2", k, hif.fwd_sel_a); end
            nvec++; if (hif.fwd_sel_b !== FW'(1)) begin nerr++; $display("FAIL hold_fwd_b%0d got %0d exp 1", k, hif.fwd_sel_b); end
            tick();
        end
        drive(1, 4, 1, 6, 1, 9, 0, 0, 0, 0);
        nvec++; if (hif.stall_fd !== 1'b0) begin nerr++; $display("FAIL hold_rel_stall got %0b exp 0", hif.stall_fd); end
        tick();
        nvec++; if (hif.fwd_sel_a !== FW'(3)) begin nerr++; $display("FAIL hold_shift_a got %0d exp 3", hif.fwd_sel_a); end
        nvec++; if (hif.fwd_sel_b !== FW'(2)) begin nerr++; $display("FAIL hold_shift_b got %0d exp 2", hif.fwd_sel_b); end
        // flush counter frozen by hold
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            nvec++; if (hif.flush_fd !== 1'b1) begin nerr++; $display("FAIL hold_flush%0d got %0b exp 1", k, hif.flush_fd); end
            tick();
        end
        idle();
        for (int k = 0; k < 3; k++) begin
            nvec++; if (hif.flush_fd !== (k < 2)) begin nerr++; $display("FAIL hold_flush_rel%0d got %0b exp %0b", k, hif.flush_fd, k < 2); end
            tick();
        end
    endtask

    task automatic test_async_reset();
        reset_dut();
        drive(1, 0, 0, 0, 0, 9, 1, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
        drive(1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
        nvec++; if (hif.fwd_sel_a !== FW'(2)) begin nerr++; $display("FAIL ar_pre_fwd got %0d exp 2", hif.fwd_sel_a); end
        nvec++; if (hif.flush_fd !== 1'b1) begin nerr++; $display("FAIL ar_pre_flush got %0b exp 1", hif.flush_fd); end
        #2 rst = 1'b0;
        #1;
        nvec++; if (hif.flush_fd  !== 1'b0) begin nerr++; $display("FAIL ar_flush got %0b exp 0", hif.flush_fd); end
        nvec++; if (hif.bubble_ex !== 1'b0) begin nerr++; $display("FAIL ar_bubble got %0b exp 0", hif.bubble_ex); end
        nvec++; if (hif.stall_fd  !== 1'b0) begin nerr++; $display("FAIL ar_stall got %0b exp 0", hif.stall_fd); end
        nvec++; if (hif.fwd_sel_a !== FW'(0)) begin nerr++; $display("FAIL ar_fwd_a got %0d exp 0", hif.fwd_sel_a); end
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive(1, 9, 1, 9, 1, 0, 0, 0, 0, 0);
        nvec++; if (hif.fwd_sel_a !== FW'(0)) begin nerr++; $display("FAIL ar_post_fwd got %0d exp 0", hif.fwd_sel_a); end
        tick();
    endtask

    task automatic test_random();
        int sa, sb; bit st, bub, fl;
        reset_dut();
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0);
            model_eval(sa, sb, st, bub, fl);
            nvec++; if (hif.stall_fd  !== st)  begin nerr++; $display("FAIL rnd_stall n=%0d got %0b exp %0b", n, hif.stall_fd, st); end
            nvec++; if (hif.bubble_ex !== bub) begin nerr++; $display("FAIL rnd_bubble n=%0d got %0b exp %0b", n, hif.bubble_ex, bub); end
            nvec++; if (hif.flush_fd  !== fl)  begin nerr++; $display("FAIL rnd_flush n=%0d got %0b exp %0b", n, hif.flush_fd, fl); end
            nvec++; if (hif.fwd_sel_a !== FW'(sa)) begin nerr++; $display("FAIL rnd_fwd_a n=%0d got %0d exp %0d", n, hif.fwd_sel_a, sa); end
            nvec++; if (hif.fwd_sel_b !== FW'(sb)) begin nerr++; $display("FAIL rnd_fwd_b n=%0d got %0d exp %0d", n, hif.fwd_sel_b, sb); end
            tick();
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_back_to_back();
        test_load_use();
        test_x0_unused();
        test_branch_flush();
        test_hold();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
